// File: rtl/lfsr_pattern_gen_pkg.sv
// rtl/lfsr_pattern_gen_pkg.sv - shared state encoding and default feedback constants for the pattern generator
package lfsr_pattern_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam int          DEFAULT_WIDTH = 20;
    localparam logic [19:0] DEFAULT_TAPS  = 20'h167;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational shift/XOR step: next = (bits<<1) ^ (bits & TAPS), zero forced to 1
module lfsr_next
    import lfsr_pattern_gen_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [WIDTH-1:0] next
);

    // An all-zero register would lock up, so it restarts the sequence at 1.
    always_comb begin
        if (bits == '0) begin
            next = WIDTH'(1);
        end else begin
            next = {bits[WIDTH-2:0], 1'b0} ^ (bits & TAPS);
        end
    end

endmodule

// File: rtl/lfsr_pattern_gen.sv
// rtl/lfsr_pattern_gen.sv - pattern generator top: run/step/hold control, MSB-event counter, flags, residue, seed match
module lfsr_pattern_gen
    import lfsr_pattern_gen_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
    parameter int               COUNT_W   = 16,
    parameter int               COUNT_SAT = 0,
    parameter int               MOD_A     = 3,
    parameter int               MOD_B     = 5,
    parameter int               MOD_C     = 13,
    parameter int               RES_W     = $clog2(MOD_C)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Run,
    input  logic               Step,
    output logic               Step_ack,
    input  logic               Load,
    input  logic [WIDTH-1:0]   Seed,
    output logic [WIDTH-1:0]   Bits,
    output logic [COUNT_W-1:0] Count,
    output logic               Wrap,
    output logic               Flag_a,
    output logic               Flag_b,
    output logic [RES_W-1:0]   Residue,
    output logic               Match,
    output logic               Busy
);

    localparam logic [COUNT_W-1:0] COUNT_PRE_MAX = {{(COUNT_W-1){1'b1}}, 1'b0};

    state_t             state, state_nxt;
    logic               step_armed;
    logic               do_step;
    logic [WIDTH-1:0]   next_bits;
    logic [WIDTH-1:0]   new_bits;
    logic [WIDTH-1:0]   seed_q;
    logic               new_flag_a, new_flag_b, new_match;
    logic [RES_W-1:0]   new_residue;

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next (
        .bits (Bits),
        .next (next_bits)
    );

    always_comb begin
        state_nxt = state;
        do_step   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Run) begin
                    state_nxt = S_RUN;
                    do_step   = 1'b1;
                end else if (Step && step_armed) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (Run) do_step = 1'b1;
                else     state_nxt = S_IDLE;
            end
            S_STEP: begin
                do_step   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (Load) begin
            state_nxt = S_IDLE;
            do_step   = 1'b0;
        end
    end

    // Flags and residue track whatever value lands in Bits this edge.
    always_comb begin
        new_bits    = Load ? Seed : next_bits;
        new_flag_a  = (new_bits % WIDTH'(MOD_A)) == '0;
        new_flag_b  = (new_bits % WIDTH'(MOD_B)) == '0;
        new_residue = RES_W'(new_bits % WIDTH'(MOD_C));
        new_match   = (next_bits == seed_q) || ((seed_q == '0) && (next_bits == WIDTH'(1)));
    end

    assign Busy = (state == S_RUN) || (state == S_STEP);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            step_armed <= 1'b1;
            Bits       <= '0;
            seed_q     <= '0;
            Count      <= '0;
            Wrap       <= 1'b0;
            Flag_a     <= 1'b0;
            Flag_b     <= 1'b0;
            Residue    <= '0;
            Match      <= 1'b0;
            Step_ack   <= 1'b0;
        end else begin
            state    <= state_nxt;
            Match    <= 1'b0;
            Step_ack <= 1'b0;
            if (Load || do_step) begin
                Bits    <= new_bits;
                Flag_a  <= new_flag_a;
                Flag_b  <= new_flag_b;
                Residue <= new_residue;
            end
            if (Load) begin
                seed_q     <= Seed;
                Count      <= '0;
                Wrap       <= 1'b0;
                step_armed <= !Step;
            end else begin
                // A held Step must be seen low before another request is taken.
                if (state == S_STEP)  step_armed <= 1'b0;
                else if (!Step)       step_armed <= 1'b1;
                if (do_step) begin
                    Match    <= new_match;
                    Step_ack <= (state == S_STEP);
                    if (next_bits[WIDTH-1]) begin
                        if (Count != '1) begin
                            Count <= Count + COUNT_W'(1);
                            if ((COUNT_SAT != 0) && (Count == COUNT_PRE_MAX)) Wrap <= 1'b1;
                        end else begin
                            Wrap <= 1'b1;
                            if (COUNT_SAT == 0) Count <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// tb/tb_lfsr_pattern_gen.sv - scoreboard bench for lfsr_pattern_gen against an arithmetic reference model
module tb_lfsr_pattern_gen;

    localparam int W = 20;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Run = 1'b0, Step = 1'b0, Load = 1'b0;
    logic [W-1:0] Seed = '0;

    logic [W-1:0] b0, b1, b2;
    logic [15:0]  c0;
    logic [1:0]   c1, c2;
    logic [3:0]   r0, r1, r2;
    logic w0, w1, w2, fa0, fa1, fa2, fb0, fb1, fb2;
    logic m0, m1, m2, k0, k1, k2, y0, y1, y2;

    int checks = 0;
    int errors = 0;

    lfsr_pattern_gen #(.WIDTH(W), .TAPS(20'h167), .COUNT_W(16), .COUNT_SAT(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .Step_ack(k0), .Load(Load), .Seed(Seed),
        .Bits(b0), .Count(c0), .Wrap(w0), .Flag_a(fa0), .Flag_b(fb0), .Residue(r0), .Match(m0), .Busy(y0));

    lfsr_pattern_gen #(.WIDTH(W), .TAPS(20'h167), .COUNT_W(2), .COUNT_SAT(0)) dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .Step_ack(k1), .Load(Load), .Seed(Seed),
        .Bits(b1), .Count(c1), .Wrap(w1), .Flag_a(fa1), .Flag_b(fb1), .Residue(r1), .Match(m1), .Busy(y1));

    lfsr_pattern_gen #(.WIDTH(W), .TAPS(20'h167), .COUNT_W(2), .COUNT_SAT(1)) dut_sat (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .Step_ack(k2), .Load(Load), .Seed(Seed),
        .Bits(b2), .Count(c2), .Wrap(w2), .Flag_a(fa2), .Flag_b(fb2), .Residue(r2), .Match(m2), .Busy(y2));

    always #5 Clk = ~Clk;

    typedef struct {
        int bits; int res;
        int cnt[3]; bit wrap[3];
        bit fa; bit fb; bit match; bit ack; bit busy;
    } exp_t;

    exp_t sb[$];

    int cw[3]  = '{16, 2, 2};
    bit sat[3] = '{1'b0, 1'b0, 1'b1};

    int m_bits, m_seed, m_res;
    int m_cnt[3];
    bit m_wrap[3];
    bit m_fa, m_fb, m_match, m_ack;
    int m_mode;   // 0 waiting, 1 free-running, 2 single step pending
    bit m_hold;   // a serviced Step has not been released yet

    function automatic int ref_next(input int b);
        if (b == 0) return 1;
        return ((b * 2) ^ (b & 32'h167)) % (1 << W);
    endfunction

    function automatic void settle(input int v);
        m_fa  = (v % 3) == 0;
        m_fb  = (v % 5) == 0;
        m_res = v % 13;
    endfunction

    function automatic void model_reset();
        m_bits = 0; m_seed = 0; m_res = 0; m_fa = 0; m_fb = 0;
        m_match = 0; m_ack = 0; m_mode = 0; m_hold = 0;
        for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_wrap[k] = 0; end
    endfunction

    function automatic void model_edge();
        bit stepping;
        int nv;
        m_match = 0; m_ack = 0; stepping = 0;
        if (Load) begin
            m_bits = int'(Seed); m_seed = int'(Seed);
            for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_wrap[k] = 0; end
            m_mode = 0; m_hold = Step;
            settle(m_bits);
            return;
        end
        case (m_mode)
            0: if (Run) begin stepping = 1; m_mode = 1; end
               else if (Step && !m_hold) m_mode = 2;
            1: if (Run) stepping = 1; else m_mode = 0;
            default: begin stepping = 1; m_ack = 1; m_mode = 0; end
        endcase
        if (m_ack) m_hold = 1;
        else if (!Step) m_hold = 0;
        if (stepping) begin
            nv = ref_next(m_bits);
            m_match = (nv == m_seed) || (m_seed == 0 && nv == 1);
            if (nv >= (1 << (W - 1))) begin
                for (int k = 0; k < 3; k++) begin
                    if (m_cnt[k] + 1 == (1 << cw[k])) begin
                        m_wrap[k] = 1;
                        if (!sat[k]) m_cnt[k] = 0;
                    end else begin
                        m_cnt[k]++;
                        if (sat[k] && m_cnt[k] == (1 << cw[k]) - 1) m_wrap[k] = 1;
                    end
                end
            end
            m_bits = nv;
            settle(nv);
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        exp_t e;
        if (Rst_n) model_edge(); else model_reset();
        e.bits = m_bits; e.res = m_res; e.fa = m_fa; e.fb = m_fb;
        e.match = m_match; e.ack = m_ack; e.busy = (m_mode != 0);
        for (int k = 0; k < 3; k++) begin e.cnt[k] = m_cnt[k]; e.wrap[k] = m_wrap[k]; end
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit l, input logic [W-1:0] sd, input int n);
        Run = r; Step = s; Load = l; Seed = sd;
        repeat (n) tick();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("bits",     64'(b0),  64'(e.bits));
                chk("count",    64'(c0),  64'(e.cnt[0]));
                chk("wrap",     64'(w0),  64'(e.wrap[0]));
                chk("flag_a",   64'(fa0), 64'(e.fa));
                chk("flag_b",   64'(fb0), 64'(e.fb));
                chk("residue",  64'(r0),  64'(e.res));
                chk("match",    64'(m0),  64'(e.match));
                chk("step_ack", 64'(k0),  64'(e.ack));
                chk("busy",     64'(y0),  64'(e.busy));
                chk("cnt_wrapmode",  64'(c1), 64'(e.cnt[1]));
                chk("wrap_wrapmode", 64'(w1), 64'(e.wrap[1]));
                chk("cnt_satmode",   64'(c2), 64'(e.cnt[2]));
                chk("wrap_satmode",  64'(w2), 64'(e.wrap[2]));
                chk("bits_satmode",  64'(b2), 64'(e.bits));
            end
        end
    end

    initial begin
        model_reset();
        drive(0, 0, 0, '0, 2);
        Rst_n = 1'b1;
        drive(0, 0, 0, '0, 1);

        // free run from reset: 1,3,5,15,25
        drive(1, 0, 0, '0, 5);
        drive(0, 0, 0, '0, 2);

        // step handshake: held Step yields one step, re-request after a low cycle
        drive(0, 1, 0, '0, 4);
        drive(0, 0, 0, '0, 1);
        drive(0, 1, 0, '0, 3);
        drive(0, 0, 0, '0, 2);

        // MSB shifted out vs. shifted in
        drive(0, 0, 1, 20'h80000, 1);
        drive(0, 1, 0, '0, 2);
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 1, 20'h40000, 1);
        drive(0, 1, 0, '0, 2);
        drive(0, 0, 0, '0, 1);

        // long run for the 2-bit counters to wrap / saturate
        drive(0, 0, 1, 20'h1, 1);
        drive(1, 0, 0, '0, 300);
        drive(1, 1, 0, '0, 3);
        drive(0, 1, 0, '0, 3);
        drive(0, 0, 0, '0, 2);

        // Load beats Run on the same edge
        drive(1, 0, 1, 20'h12345, 1);
        drive(1, 0, 0, '0, 3);
        drive(0, 0, 0, '0, 1);

        // asynchronous reset while a single step is pending
        drive(0, 1, 0, '0, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_bits",  64'(b0), 64'd0);
        chk("async_rst_busy",  64'(y0), 64'd0);
        chk("async_rst_ack",   64'(k0), 64'd0);
        chk("async_rst_count", 64'(c0), 64'd0);
        chk("async_rst_res",   64'(r0), 64'd0);
        Step = 1'b0;
        tick();
        Rst_n = 1'b1;
        drive(0, 0, 0, '0, 2);

        // randomized control mix
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            Load = (r < 6);
            Seed = (r == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 7) == 0) Run = ~Run;
            if ($urandom_range(0, 3) == 0) Step = ~Step;
            tick();
        end
        drive(0, 0, 0, '0, 2);

        // revisit of the loaded seed
        drive(0, 0, 1, 20'h1, 1);
        Load = 1'b0;
        Run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (m_match) break;
        end
        drive(0, 0, 0, '0, 3);

        #5;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
